// File: rtl/bday_digit_source.sv
// Birthday digit source: debounced date toggle plus optional marquee.
// Define SCROLL_EN to build the KEY[0] marquee mode (FSM, tick counter, rot).

module bday_debounce #(
    parameter int CYCLES = 500000
) (
    input  logic clk,
    input  logic reset,
    input  logic key,
    output logic press
);
    localparam int CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;

    logic          s1;
    logic          s2;
    logic          deb;
    logic [CW-1:0] cnt;
    logic          hit;

    assign hit   = (s2 != deb) && (cnt == CW'(CYCLES - 1));
    assign press = hit && deb;

    // Two-flop synchronizer and stable-sample counter; deb flips after a full run.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1  <= 1'b1;
            s2  <= 1'b1;
            deb <= 1'b1;
            cnt <= '0;
        end else begin
            s1 <= key;
            s2 <= s1;
            if (s2 == deb) begin
                cnt <= '0;
            end else if (hit) begin
                deb <= s2;
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

module bday_digit_source #(
    parameter logic [23:0] DATE_A          = 24'h030200,
    parameter logic [23:0] DATE_B          = 24'h080700,
    parameter int          DEBOUNCE_CYCLES = 500000,
    parameter int          SCROLL_CYCLES   = 25000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  KEY,
    output logic [23:0] digits,
    output logic        date_sel,
    output logic        scrolling
);
    logic        press1;
    logic [2:0]  rot;
    logic [23:0] date;

    bday_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_deb1 (
        .clk   (clk),
        .reset (reset),
        .key   (KEY[1]),
        .press (press1)
    );

    // Each KEY[1] press swaps which stored date is shown.
    always_ff @(posedge clk) begin
        if (reset) begin
            date_sel <= 1'b0;
        end else if (press1) begin
            date_sel <= ~date_sel;
        end
    end

`ifdef SCROLL_EN
    localparam int TW = (SCROLL_CYCLES > 1) ? $clog2(SCROLL_CYCLES) : 1;

    typedef enum logic {
        STATIC = 1'b0,
        SCROLL = 1'b1
    } mode_t;

    logic          press0;
    mode_t         state;
    mode_t         state_n;
    logic [TW-1:0] tick;
    logic [TW-1:0] tick_n;
    logic [2:0]    rot_q;
    logic [2:0]    rot_n;

    bday_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_deb0 (
        .clk   (clk),
        .reset (reset),
        .key   (KEY[0]),
        .press (press0)
    );

    // Mode, tick and rotation registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= STATIC;
            tick  <= '0;
            rot_q <= 3'd0;
        end else begin
            state <= state_n;
            tick  <= tick_n;
            rot_q <= rot_n;
        end
    end

    // KEY[0] toggles the marquee; while running, rot steps on each tick wrap.
    always_comb begin
        state_n = state;
        tick_n  = tick;
        rot_n   = rot_q;
        case (state)
            STATIC: begin
                if (press0) begin
                    state_n = SCROLL;
                    tick_n  = '0;
                end
            end
            SCROLL: begin
                if (press0) begin
                    state_n = STATIC;
                    tick_n  = '0;
                    rot_n   = 3'd0;
                end else if (tick == TW'(SCROLL_CYCLES - 1)) begin
                    tick_n = '0;
                    rot_n  = (rot_q == 3'd5) ? 3'd0 : rot_q + 3'd1;
                end else begin
                    tick_n = tick + 1'b1;
                end
            end
            default: begin
                state_n = STATIC;
            end
        endcase
    end

    assign scrolling = (state == SCROLL);
    assign rot       = rot_q;
`else
    localparam int unused_scroll = SCROLL_CYCLES;
    logic unused_key0;

    assign unused_key0 = KEY[0];
    assign scrolling   = 1'b0;
    assign rot         = 3'd0;
`endif

    assign date = date_sel ? DATE_B : DATE_A;

    // Rotate the selected date left by one digit per rot step.
    always_comb begin
        digits = date;
        case (rot)
            3'd1:    digits = {date[19:0], date[23:20]};
            3'd2:    digits = {date[15:0], date[23:16]};
            3'd3:    digits = {date[11:0], date[23:12]};
            3'd4:    digits = {date[7:0],  date[23:8]};
            3'd5:    digits = {date[3:0],  date[23:4]};
            default: digits = date;
        endcase
    end
endmodule

// File: tb/tb_bday_digit_source.sv
// Bench for bday_digit_source: directed vector table plus random keys
// checked against a run-length debounce / elapsed-time marquee model.
`timescale 1ns/1ps

module tb_bday_digit_source;
    localparam int          D  = 4;
    localparam int          S  = 8;
    localparam logic [23:0] DA = 24'h030200;
    localparam logic [23:0] DB = 24'h080700;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  KEY = 2'b11;
    logic [23:0] digits;
    logic        date_sel;
    logic        scrolling;

    always #5 clk = ~clk;

    bday_digit_source #(
        .DATE_A          (DA),
        .DATE_B          (DB),
        .DEBOUNCE_CYCLES (D),
        .SCROLL_CYCLES   (S)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .KEY       (KEY),
        .digits    (digits),
        .date_sel  (date_sel),
        .scrolling (scrolling)
    );

    int checks = 0;
    int passes = 0;

    // Reference model state.
    logic [1:0] hist[$];
    logic [1:0] m_deb = 2'b11;
    int         m_run[2];
    logic       m_sel = 1'b0;
    logic       m_scr = 1'b0;
    int         m_elapsed = 0;

    function automatic logic [23:0] rotl(input logic [23:0] d, input int r);
        logic [3:0]  dig[6];
        logic [23:0] o;
        for (int i = 0; i < 6; i++) dig[i] = d[4*i +: 4];
        for (int i = 0; i < 6; i++) o[4*i +: 4] = dig[(i - r + 6) % 6];
        return o;
    endfunction

    function automatic logic [23:0] m_digits();
        int r;
        r = m_scr ? (m_elapsed / S) % 6 : 0;
        return rotl(m_sel ? DB : DA, r);
    endfunction

    task automatic model_step(input logic rs, input logic [1:0] k);
        logic [1:0] s;
        logic [1:0] pr;
        if (rs) begin
            hist.delete();
            m_deb     = 2'b11;
            m_run[0]  = 0;
            m_run[1]  = 0;
            m_sel     = 1'b0;
            m_scr     = 1'b0;
            m_elapsed = 0;
            return;
        end
        s  = (hist.size() >= 2) ? hist[hist.size() - 2] : 2'b11;
        pr = 2'b00;
        for (int i = 0; i < 2; i++) begin
            if (s[i] != m_deb[i]) begin
                m_run[i]++;
                if (m_run[i] == D) begin
                    pr[i]    = m_deb[i];
                    m_deb[i] = s[i];
                    m_run[i] = 0;
                end
            end else begin
                m_run[i] = 0;
            end
        end
        hist.push_back(k);
        if (hist.size() > 4) void'(hist.pop_front());
        if (pr[1]) m_sel = ~m_sel;
`ifdef SCROLL_EN
        if (pr[0]) begin
            m_scr     = ~m_scr;
            m_elapsed = 0;
        end else if (m_scr) begin
            m_elapsed++;
        end
`endif
    endtask

    task automatic check(input string name, input logic [23:0] act, input logic [23:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h want %h", name, act, exp);
    endtask

    task automatic cycle(input logic rs, input logic [1:0] k);
        reset = rs;
        KEY   = k;
        @(posedge clk);
        model_step(rs, k);
        @(negedge clk);
    endtask

    typedef struct {
        logic        rst;
        logic [1:0]  key;
        int          n;
        logic        sel;
        logic        scr;
        logic [23:0] dig;
    } vec_t;

    vec_t tbl[$];

    initial begin
        tbl.push_back('{1'b1, 2'b11, 3,  1'b0, 1'b0, DA});
        tbl.push_back('{1'b0, 2'b11, 2,  1'b0, 1'b0, DA});
        tbl.push_back('{1'b0, 2'b01, 5,  1'b0, 1'b0, DA});
        tbl.push_back('{1'b0, 2'b01, 1,  1'b1, 1'b0, DB});
        tbl.push_back('{1'b0, 2'b01, 20, 1'b1, 1'b0, DB});
        tbl.push_back('{1'b0, 2'b11, 6,  1'b1, 1'b0, DB});
        tbl.push_back('{1'b0, 2'b11, 10, 1'b1, 1'b0, DB});
        tbl.push_back('{1'b1, 2'b11, 1,  1'b0, 1'b0, DA});
        for (int i = 0; i < 10; i++) begin
            tbl.push_back('{1'b0, 2'b01, 3, 1'b0, 1'b0, DA});
            tbl.push_back('{1'b0, 2'b11, 3, 1'b0, 1'b0, DA});
        end
`ifdef SCROLL_EN
        tbl.push_back('{1'b0, 2'b10, 5,  1'b0, 1'b0, DA});
        tbl.push_back('{1'b0, 2'b10, 1,  1'b0, 1'b1, DA});
        tbl.push_back('{1'b0, 2'b11, 7,  1'b0, 1'b1, DA});
        tbl.push_back('{1'b0, 2'b11, 1,  1'b0, 1'b1, 24'h302000});
        tbl.push_back('{1'b0, 2'b11, 40, 1'b0, 1'b1, DA});
        tbl.push_back('{1'b0, 2'b11, 16, 1'b0, 1'b1, 24'h020003});
        tbl.push_back('{1'b0, 2'b01, 6,  1'b1, 1'b1, 24'h070008});
        tbl.push_back('{1'b0, 2'b01, 1,  1'b1, 1'b1, 24'h070008});
        tbl.push_back('{1'b0, 2'b11, 1,  1'b1, 1'b1, 24'h700080});
        tbl.push_back('{1'b0, 2'b11, 3,  1'b1, 1'b1, 24'h700080});
        tbl.push_back('{1'b0, 2'b10, 6,  1'b1, 1'b0, DB});
        tbl.push_back('{1'b0, 2'b11, 6,  1'b1, 1'b0, DB});
        tbl.push_back('{1'b0, 2'b10, 6,  1'b1, 1'b1, DB});
        tbl.push_back('{1'b0, 2'b11, 5,  1'b1, 1'b1, DB});
        tbl.push_back('{1'b1, 2'b11, 1,  1'b0, 1'b0, DA});
`else
        tbl.push_back('{1'b0, 2'b10, 20, 1'b0, 1'b0, DA});
        tbl.push_back('{1'b0, 2'b11, 8,  1'b0, 1'b0, DA});
`endif

        for (int i = 0; i < tbl.size(); i++) begin
            repeat (tbl[i].n) cycle(tbl[i].rst, tbl[i].key);
            check($sformatf("vec%0d date_sel", i), {23'd0, date_sel}, {23'd0, tbl[i].sel});
            check($sformatf("vec%0d scrolling", i), {23'd0, scrolling}, {23'd0, tbl[i].scr});
            check($sformatf("vec%0d digits", i), digits, tbl[i].dig);
        end

        cycle(1'b1, 2'b11);
        for (int seg = 0; seg < 400; seg++) begin
            logic [1:0] k;
            int         len;
            logic       rs;
            k   = 2'($urandom);
            len = $urandom_range(1, 9);
            rs  = ($urandom_range(0, 60) == 0);
            for (int c = 0; c < len; c++) begin
                cycle(rs && (c == 0), k);
                check("rand date_sel", {23'd0, date_sel}, {23'd0, m_sel});
                check("rand scrolling", {23'd0, scrolling}, {23'd0, m_scr});
                check("rand digits", digits, m_digits());
            end
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
